// File: rtl/shared_ram_pkg.sv
// ---------------------------------------------------------------------------
// shared_ram_pkg
// Shared types and constants for the dual-slave on-chip RAM.
//   port_idx_t     : index of a slave port (0 or 1)
//   access_kind_e  : kind of access granted this cycle
//   READ_LAT       : read latency in cycles after the accept edge
// Configuration macro: SHARED_RAM_OUTREG_EN (adds a registered output stage).
// ---------------------------------------------------------------------------
package shared_ram_pkg;

  typedef logic [0:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } access_kind_e;

`ifdef SHARED_RAM_OUTREG_EN
  localparam int READ_LAT = 2;
`else
  localparam int READ_LAT = 1;
`endif

endpackage

// File: rtl/shared_onchip_ram_if.sv
// ---------------------------------------------------------------------------
// shared_onchip_ram_if
// One slave bus port of the shared RAM (address/byteenable/chipselect/read/
// write/writedata towards the RAM; readdata/waitrequest/readdatavalid back).
//   modport master : drives the request side
//   modport slave  : drives the response side (used by the RAM)
// ---------------------------------------------------------------------------
interface shared_onchip_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);

  logic [ADDR_W-1:0]   sp_address;
  logic [DATA_W/8-1:0] sp_byteenable;
  logic                sp_chipselect;
  logic                sp_read;
  logic                sp_write;
  logic [DATA_W-1:0]   sp_writedata;
  logic [DATA_W-1:0]   sp_readdata;
  logic                sp_waitrequest;
  logic                sp_readdatavalid;

  modport master (
    output sp_address, sp_byteenable, sp_chipselect, sp_read, sp_write, sp_writedata,
    input  sp_readdata, sp_waitrequest, sp_readdatavalid
  );

  modport slave (
    input  sp_address, sp_byteenable, sp_chipselect, sp_read, sp_write, sp_writedata,
    output sp_readdata, sp_waitrequest, sp_readdatavalid
  );

endinterface

// File: rtl/shared_ram_rr_arb.sv
// ---------------------------------------------------------------------------
// shared_ram_rr_arb
// Two-requester round-robin arbiter. A lone requester is granted at once; on
// a conflict the port not granted last wins. No grant while i_clken=0 or
// while reset is asserted.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_request    : request vector, bit p = slave port p
//   i_clken      : enables new grants
//   o_grant      : one-hot (or zero) grant, valid in the same cycle
// ---------------------------------------------------------------------------
module shared_ram_rr_arb
  import shared_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_request,
  input  logic       i_clken,
  output logic [1:0] o_grant
);

  port_idx_t  r_last_grant;
  logic [1:0] w_grant;

  // Grant decision: single requester wins, conflict goes to the other port.
  always_comb begin
    w_grant = 2'b00;
    if (i_clken && reset_n) begin
      case (i_request)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = (r_last_grant == 1'b1) ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end else begin
      w_grant = 2'b00;
    end
  end

  // Remember which port was granted last; reset value makes port 0 win first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (w_grant[0]) begin
      r_last_grant <= 1'b0;
    end else if (w_grant[1]) begin
      r_last_grant <= 1'b1;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/shared_onchip_ram.sv
// ---------------------------------------------------------------------------
// shared_onchip_ram
// Single-port word RAM shared by two slave bus ports through a round-robin
// arbiter. One access per cycle; writes honour byte enables; reads return
// data with readdatavalid one cycle after the accept edge (two cycles when
// SHARED_RAM_OUTREG_EN is defined). Addresses >= DEPTH ignore writes and
// read as zero.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset (deassertion synchronised outside)
//   clken    : enables new grants; in-flight reads still complete
//   s0, s1   : slave ports (shared_onchip_ram_if.slave)
// Parameters: DATA_W, DEPTH, ADDR_W, INIT_FILE (power-up image attached by
// the device memory-initialisation flow; the array has no reset or load logic).
// Configuration macro: SHARED_RAM_OUTREG_EN.
// ---------------------------------------------------------------------------
module shared_onchip_ram
  import shared_ram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 10000,
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = "shared_onchip_ram.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  shared_onchip_ram_if.slave  s0,
  shared_onchip_ram_if.slave  s1
);

  localparam int              BE_W    = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  port_idx_t         w_sel;
  access_kind_e      w_kind;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rdata;

  logic [1:0]        r_rd_vld;
  logic [DATA_W-1:0] r_rd_data [2];
  logic [1:0]        w_out_vld;
  logic [DATA_W-1:0] w_out_data [2];

  assign w_req[0] = s0.sp_chipselect & (s0.sp_read | s0.sp_write);
  assign w_req[1] = s1.sp_chipselect & (s1.sp_read | s1.sp_write);

  shared_ram_rr_arb u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_request (w_req),
    .i_clken   (clken),
    .o_grant   (w_grant)
  );

  // Route the granted port onto the single array access; write wins over read.
  always_comb begin
    w_sel   = 1'b0;
    w_kind  = IDLE;
    w_addr  = '0;
    w_be    = '0;
    w_wdata = '0;
    if (w_grant[0]) begin
      w_sel   = 1'b0;
      w_kind  = s0.sp_write ? WR : RD;
      w_addr  = s0.sp_address;
      w_be    = s0.sp_byteenable;
      w_wdata = s0.sp_writedata;
    end else if (w_grant[1]) begin
      w_sel   = 1'b1;
      w_kind  = s1.sp_write ? WR : RD;
      w_addr  = s1.sp_address;
      w_be    = s1.sp_byteenable;
      w_wdata = s1.sp_writedata;
    end else begin
      w_kind  = IDLE;
    end
  end

  assign w_in_range = ({1'b0, w_addr} < DEPTH_L);

  // Array read; holes above DEPTH read as zero.
  always_comb begin
    w_rdata = '0;
    if (w_in_range) begin
      w_rdata = r_mem[w_addr];
    end else begin
      w_rdata = '0;
    end
  end

  // Byte-lane write into the array; no reset so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (w_kind == WR && w_in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_be[b]) begin
          r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
    end
  end

  // First read stage: capture array data per port; data held between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        r_rd_data[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_rd_vld[p] <= (w_kind == RD) && (w_sel == port_idx_t'(p));
        if ((w_kind == RD) && (w_sel == port_idx_t'(p))) begin
          r_rd_data[p] <= w_rdata;
        end
      end
    end
  end

`ifdef SHARED_RAM_OUTREG_EN
  logic [1:0]        r_out_vld;
  logic [DATA_W-1:0] r_out_data [2];

  // Optional output register stage: valid and data delayed one more cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_vld <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        r_out_data[p] <= '0;
      end
    end else begin
      r_out_vld <= r_rd_vld;
      for (int p = 0; p < 2; p++) begin
        if (r_rd_vld[p]) begin
          r_out_data[p] <= r_rd_data[p];
        end
      end
    end
  end

  assign w_out_vld     = r_out_vld;
  assign w_out_data[0] = r_out_data[0];
  assign w_out_data[1] = r_out_data[1];
`else
  assign w_out_vld     = r_rd_vld;
  assign w_out_data[0] = r_rd_data[0];
  assign w_out_data[1] = r_rd_data[1];
`endif

  assign s0.sp_readdata      = w_out_data[0];
  assign s1.sp_readdata      = w_out_data[1];
  assign s0.sp_readdatavalid = w_out_vld[0];
  assign s1.sp_readdatavalid = w_out_vld[1];

  // Stall a requester in any cycle it is not the one granted.
  assign s0.sp_waitrequest = w_req[0] & ~w_grant[0];
  assign s1.sp_waitrequest = w_req[1] & ~w_grant[1];

endmodule

// File: tb/tb_shared_onchip_ram.sv
// ---------------------------------------------------------------------------
// tb_shared_onchip_ram
// Directed stimulus against a behavioural model of the shared RAM (word map,
// round-robin rule, queue of pending read responses). Every cycle the model
// predicts waitrequest, readdatavalid and readdata for both ports; literal
// expectations pin key results.
// ---------------------------------------------------------------------------
module tb_shared_onchip_ram;

  localparam int DW    = 32;
  localparam int AW    = 14;
  localparam int DEPTH = 10000;
`ifdef SHARED_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic reset_n;
  logic clken;

  always #5 clk = ~clk;

  shared_onchip_ram_if #(.DATA_W(DW), .ADDR_W(AW)) s0_if ();
  shared_onchip_ram_if #(.DATA_W(DW), .ADDR_W(AW)) s1_if ();

  shared_onchip_ram #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .s0      (s0_if),
    .s1      (s1_if)
  );

  // model state
  logic [31:0] mdl_mem [int];
  rd_t         pend [$];
  int          last_g;
  logic [31:0] exp_last [2];
  int          cyc;
  int          gnt_log [$];
  int          vld_cnt [2];
  logic        obs_v [2];
  logic [31:0] obs_d [2];
  logic        obs_wr [2];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drv(input int p, input logic rd, input logic wr,
                     input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      s0_if.sp_chipselect = rd | wr; s0_if.sp_read = rd; s0_if.sp_write = wr;
      s0_if.sp_address = a; s0_if.sp_byteenable = be; s0_if.sp_writedata = d;
    end else begin
      s1_if.sp_chipselect = rd | wr; s1_if.sp_read = rd; s1_if.sp_write = wr;
      s1_if.sp_address = a; s1_if.sp_byteenable = be; s1_if.sp_writedata = d;
    end
  endtask

  task automatic idle_all();
    drv(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    drv(1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  // One bus cycle: compare DUT with model, apply the accept edge to the model.
  task automatic cycle();
    logic [1:0]    req;
    int            g;
    logic          ev;
    logic          ew;
    logic [31:0]   ed;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          wr;
    logic [31:0]   cur;
    rd_t           keep [$];
    #1;
    if (!reset_n) begin
      pend.delete();
      exp_last[0] = 32'h0;
      exp_last[1] = 32'h0;
      last_g = 1;
    end
    obs_v[0] = s0_if.sp_readdatavalid;  obs_v[1] = s1_if.sp_readdatavalid;
    obs_d[0] = s0_if.sp_readdata;       obs_d[1] = s1_if.sp_readdata;
    obs_wr[0] = s0_if.sp_waitrequest;   obs_wr[1] = s1_if.sp_waitrequest;
    for (int p = 0; p < 2; p++) begin
      ev = 1'b0;
      ed = exp_last[p];
      foreach (pend[i]) begin
        if (pend[i].due == cyc && pend[i].port == p) begin
          ev = 1'b1;
          ed = pend[i].data;
        end
      end
      chk($sformatf("readdatavalid%0d", p), {31'b0, obs_v[p]}, {31'b0, ev});
      chk($sformatf("readdata%0d", p), obs_d[p], ed);
      if (ev) exp_last[p] = ed;
      if (obs_v[p]) vld_cnt[p]++;
    end
    req[0] = s0_if.sp_chipselect & (s0_if.sp_read | s0_if.sp_write);
    req[1] = s1_if.sp_chipselect & (s1_if.sp_read | s1_if.sp_write);
    g = -1;
    if (reset_n && clken) begin
      if (req == 2'b11)  g = (last_g == 1) ? 0 : 1;
      else if (req[0])   g = 0;
      else if (req[1])   g = 1;
    end
    for (int p = 0; p < 2; p++) begin
      ew = req[p] && (g != p);
      chk($sformatf("waitrequest%0d", p), {31'b0, obs_wr[p]}, {31'b0, ew});
    end
    gnt_log.push_back(g);
    if (g >= 0) begin
      if (g == 0) begin
        a = s0_if.sp_address; be = s0_if.sp_byteenable; wd = s0_if.sp_writedata; wr = s0_if.sp_write;
      end else begin
        a = s1_if.sp_address; be = s1_if.sp_byteenable; wd = s1_if.sp_writedata; wr = s1_if.sp_write;
      end
      last_g = g;
      cur = 32'h0;
      if (int'(a) < DEPTH && mdl_mem.exists(int'(a))) cur = mdl_mem[int'(a)];
      if (wr) begin
        if (int'(a) < DEPTH) begin
          for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
          mdl_mem[int'(a)] = cur;
        end
      end else begin
        pend.push_back('{due: cyc + LAT, port: g, data: cur});
      end
    end
    foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
    pend = keep;
    @(negedge clk);
    cyc++;
  endtask

  int exp_g [4] = '{0, 1, 0, 1};
  int g0;

  initial begin
    reset_n = 1'b1;
    clken   = 1'b1;
    cyc     = 0;
    last_g  = 1;
    exp_last[0] = 32'h0; exp_last[1] = 32'h0;
    vld_cnt[0] = 0; vld_cnt[1] = 0;
    idle_all();
    #2 reset_n = 1'b0;
    @(negedge clk);

    // reset state
    cycle();
    cycle();
    chk("reset_rdata0", obs_d[0], 32'h0);
    chk("reset_valid1", {31'b0, obs_v[1]}, 32'h0);
    reset_n = 1'b1;

    // single write then read
    drv(0, 1'b0, 1'b1, 14'd5, 4'hF, 32'hDEADBEEF); cycle();
    drv(0, 1'b1, 1'b0, 14'd5, 4'hF, 32'h0);        cycle();
    idle_all(); repeat (LAT) cycle();
    chk("wr_rd_valid0", {31'b0, obs_v[0]}, 32'h1);
    chk("wr_rd_data0", obs_d[0], 32'hDEADBEEF);
    chk("wr_rd_valid1", {31'b0, obs_v[1]}, 32'h0);

    // byte enables
    drv(0, 1'b0, 1'b1, 14'd7, 4'hF, 32'h11223344); cycle();
    idle_all(); drv(1, 1'b0, 1'b1, 14'd7, 4'b0101, 32'hAABBCCDD); cycle();
    drv(1, 1'b1, 1'b0, 14'd7, 4'hF, 32'h0); cycle();
    idle_all(); repeat (LAT) cycle();
    chk("byteen_data1", obs_d[1], 32'h11BB33DD);
    chk("byteen_model", mdl_mem[7], 32'h11BB33DD);

    // out of range
    drv(0, 1'b0, 1'b1, 14'd9999, 4'hF, 32'h12345678);  cycle();
    drv(0, 1'b0, 1'b1, 14'd10000, 4'hF, 32'hFFFFFFFF); cycle();
    drv(0, 1'b1, 1'b0, 14'd10000, 4'hF, 32'h0);        cycle();
    idle_all(); repeat (LAT) cycle();
    chk("oor_valid", {31'b0, obs_v[0]}, 32'h1);
    chk("oor_data", obs_d[0], 32'h0);
    drv(0, 1'b1, 1'b0, 14'd9999, 4'hF, 32'h0); cycle();
    idle_all(); repeat (LAT) cycle();
    chk("oor_neighbour", obs_d[0], 32'h12345678);

    // read-old / write-before-read ordering on consecutive grants
    drv(0, 1'b1, 1'b0, 14'd5, 4'hF, 32'h0); cycle();
    idle_all(); drv(1, 1'b0, 1'b1, 14'd5, 4'hF, 32'hCAFEF00D); cycle();
    idle_all(); drv(0, 1'b1, 1'b0, 14'd5, 4'hF, 32'h0); cycle();
    idle_all(); repeat (LAT) cycle();
    chk("wbr_new_data", obs_d[0], 32'hCAFEF00D);

    // back-to-back reads, no bubbles
    drv(0, 1'b1, 1'b0, 14'd7, 4'hF, 32'h0);     cycle();
    drv(0, 1'b1, 1'b0, 14'd9999, 4'hF, 32'h0);  cycle();
    drv(0, 1'b1, 1'b0, 14'd10000, 4'hF, 32'h0); cycle();
    drv(0, 1'b1, 1'b0, 14'd5, 4'hF, 32'h0);     cycle();
    idle_all(); repeat (LAT) cycle();

    // clken low blocks grants
    drv(0, 1'b0, 1'b1, 14'd20, 4'hF, 32'h5555AAAA); cycle();
    clken = 1'b0;
    drv(0, 1'b0, 1'b1, 14'd20, 4'hF, 32'h00000000); repeat (3) cycle();
    chk("clken_wait0", {31'b0, obs_wr[0]}, 32'h1);
    clken = 1'b1; idle_all(); cycle();
    drv(0, 1'b1, 1'b0, 14'd20, 4'hF, 32'h0); cycle();
    clken = 1'b0; idle_all(); repeat (LAT) cycle();
    chk("clken_inflight_valid", {31'b0, obs_v[0]}, 32'h1);
    chk("clken_no_write", obs_d[0], 32'h5555AAAA);
    clken = 1'b1;

    // data for the conflict test, then leave last grant on port 0
    drv(0, 1'b0, 1'b1, 14'd1, 4'hF, 32'h01010101); cycle();
    idle_all(); drv(1, 1'b0, 1'b1, 14'd2, 4'hF, 32'h02020202); cycle();
    idle_all(); drv(0, 1'b1, 1'b0, 14'd1, 4'hF, 32'h0); cycle();

    // reset right after a read accept drops the response
    idle_all();
    vld_cnt[0] = 0; vld_cnt[1] = 0;
    reset_n = 1'b0; cycle();
    reset_n = 1'b1; repeat (LAT + 1) cycle();
    chk("reset_discard", vld_cnt[0], 32'd0);

    // conflict, round-robin starting at port 0
    vld_cnt[0] = 0; vld_cnt[1] = 0;
    g0 = gnt_log.size();
    drv(0, 1'b1, 1'b0, 14'd1, 4'hF, 32'h0);
    drv(1, 1'b1, 1'b0, 14'd2, 4'hF, 32'h0);
    repeat (4) cycle();
    idle_all(); repeat (LAT) cycle();
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), gnt_log[g0 + i], exp_g[i]);
    chk("rr_valids0", vld_cnt[0], 32'd2);
    chk("rr_valids1", vld_cnt[1], 32'd2);
    chk("rr_data1", obs_d[1], 32'h02020202);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shared_onchip_ram.md
SHARED_ONCHIP_RAM -- requirements
Module: shared_onchip_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the word width in bits (a multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 10000, meaning the number of words.
REQ-003 SHALL have parameter ADDR_W, default 14, meaning the word address width, with 2**ADDR_W >= DEPTH.
REQ-004 SHALL have parameter INIT_FILE, default "shared_onchip_ram.hex", meaning the power-up contents file.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-007 SHALL have port clken, input, 1 bit: clock enable for new grants.
REQ-008 SHALL have, for each slave port p in {0,1}, the inputs sp_address (ADDR_W), sp_byteenable (DATA_W/8), sp_chipselect (1), sp_read (1), sp_write (1) and sp_writedata (DATA_W).
REQ-009 SHALL have, for each p, the outputs sp_readdata (DATA_W), sp_waitrequest (1) and sp_readdatavalid (1).

Function
REQ-010 SHALL treat port p as requesting when sp_chipselect & (sp_read | sp_write); if both read and write are high, the access is a write.
REQ-011 SHALL grant at most one request per cycle, and only when clken=1.
REQ-012 SHALL grant a single requester immediately; on conflict it SHALL grant the port not granted last (round-robin), with last_grant=1 after reset so port 0 wins the first conflict.
REQ-013 SHALL drive sp_waitrequest combinationally: high while port p requests and is not granted this cycle, and low otherwise; a master holds its request until waitrequest is low.
REQ-014 SHALL, for a granted write, update only the byte lanes whose byteenable bit is set, at the same edge; the write response is implicit, with no readdatavalid.
REQ-015 SHALL, for a granted read, assert sp_readdatavalid for exactly one cycle with sp_readdata, with read latency 1 cycle after the accept edge (2 with SHARED_RAM_OUTREG_EN).
REQ-016 SHALL, for any address >= DEPTH, ignore writes and return a read of all zeros with the normal latency and valid.
REQ-017 SHALL return old data for a read and a write to the same address on consecutive grants, with write-before-read ordering: a read granted after a write sees the new data.
REQ-018 SHALL block new grants while clken=0 (waitrequest high for requesters) and still complete in-flight reads.
REQ-019 SHALL support fully pipelined back-to-back reads, one per cycle per grant, with no bubbles.
REQ-020 SHALL hold sp_readdata at its last value when readdatavalid=0.

Reset
REQ-021 SHALL, while reset_n=0, drive both readdatavalid low and both readdata to 0, set last_grant=1 and clear the read pipeline valid bits.
REQ-022 SHALL discard reads in flight when reset is asserted mid-operation; no valid SHALL appear after release for them.
REQ-023 SHALL NOT alter the memory contents on reset; the array holds INIT_FILE from configuration only.
REQ-024 SHALL release reset asynchronously on assertion and treat deassertion as synchronous to clk, via an external synchronizer.

Configuration
REQ-025 SHALL use macro SHARED_RAM_OUTREG_EN: when defined, add a registered output stage giving read latency 2 and readdatavalid delayed in step; when undefined, read latency is 1 from the array register.

Structure
REQ-026 SHALL place in package shared_ram_pkg: the port index typedef (1 bit), the access kind enum {IDLE, RD, WR}, and the read latency constant derived from the macro.
REQ-027 SHALL place the round-robin arbiter in sub-module shared_ram_rr_arb (request[1:0], clken -> grant[1:0], last_grant register); the memory array is inferred in the top module.

Verification
REQ-028 Single write then read: s0 writes 0xDEADBEEF to address 5 with byteenable 0xF, then s0 reads address 5 -> s0_readdatavalid is high 1 cycle after accept (2 with OUTREG) with data 0xDEADBEEF; s1_readdatavalid stays 0.
REQ-029 Conflict round-robin: both ports read addresses 1 and 2 continuously for 4 cycles -> grants alternate 0,1,0,1, each waitrequest is high on alternate cycles, and each port receives 2 valids with the correct data.
REQ-030 Byte enables: address 7 = 0x11223344; s1 writes 0xAABBCCDD with byteenable 0b0101; read back -> 0x11BB33DD.
REQ-031 Out-of-range: write 0xFFFFFFFF to address 10000, then read address 10000 -> readdata 0x00000000 with valid, and address 9999 is unchanged.
REQ-032 clken/reset: clken=0 with s0 requesting -> s0_waitrequest is held high and no write occurs; reset_n pulsed low one cycle after a read accept -> no readdatavalid follows, and the first conflict after release goes to port 0.
